// File: rtl/regression_predictor.sv
// -----------------------------------------------------------------------------
// regression_predictor
// Evaluates a fitted linear model yhat = b0 + b1*x over a stream of (x, y)
// test samples. Each sample produces a prediction and a residual. The block
// also accumulates the saturated sum of squared residuals (SSE) over one run.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start               begin a run (sampled in IDLE only); latches b0/b1
//   b0, b1              intercept / slope, signed Q(W-FRAC).FRAC
//   in_valid, in_ready  sample handshake; a sample is taken when both are high
//   x, y, in_last       test input, observed output, final-sample marker
//   out_valid           one-cycle pulse per sample with yhat/resid
//   yhat, resid         prediction and y - yhat (saturated)
//   sse                 running saturated sum of squared residuals
//   count               samples emitted this run (saturating)
//   busy, done          run in progress / one-cycle completion pulse
// -----------------------------------------------------------------------------
module regression_predictor #(
    parameter int W    = 20,
    parameter int FRAC = 10,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [W-1:0]    b0,
    input  logic [W-1:0]    b1,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    x,
    input  logic [W-1:0]    y,
    input  logic            in_last,
    output logic            out_valid,
    output logic [W-1:0]    yhat,
    output logic [W-1:0]    resid,
    output logic [W-1:0]    sse,
    output logic [CNTW-1:0] count,
    output logic            busy,
    output logic            done
);

    localparam int WW = 2 * W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Sign-extend a W-bit value to the double-width working precision.
    function automatic logic [WW-1:0] sext(input logic [W-1:0] v);
        sext = {{W{v[W-1]}}, v};
    endfunction

    // Clamp a double-width signed value into the signed W-bit range.
    function automatic logic [W-1:0] sat_w(input logic signed [WW-1:0] v);
        logic signed [WW-1:0] hi;
        logic signed [WW-1:0] lo;
        hi = {{(W+1){1'b0}}, {(W-1){1'b1}}};
        lo = {{(W+1){1'b1}}, {(W-1){1'b0}}};
        if (v > hi) begin
            sat_w = {1'b0, {(W-1){1'b1}}};
        end else if (v < lo) begin
            sat_w = {1'b1, {(W-1){1'b0}}};
        end else begin
            sat_w = v[W-1:0];
        end
    endfunction

    state_t               state_r;
    logic [W-1:0]         b0_r;
    logic [W-1:0]         b1_r;
    // Input capture stage: the multiplier works from registers, not pins.
    logic [W-1:0]         x0_r;
    logic [W-1:0]         y0_r;
    logic                 v0_r;
    logic                 last0_r;
    // Product stage.
    logic [W-1:0]         p1_r;
    logic [W-1:0]         y1_r;
    logic                 v1_r;
    logic                 last1_r;
    // Marks the out_valid pulse that carries the final sample of the run.
    logic                 last2_r;

    logic                 accept_s;
    logic                 start_s;
    logic                 final_s;
    logic signed [WW-1:0] prod_s;
    logic signed [WW-1:0] sum_s;
    logic signed [WW-1:0] diff_s;
    logic signed [WW-1:0] sq_prod_s;
    logic signed [WW-1:0] sse_sum_s;
    logic [W-1:0]         p_s;
    logic [W-1:0]         yhat_s;
    logic [W-1:0]         resid_s;
    logic [W-1:0]         sq_s;
    logic [W-1:0]         sse_next_s;

    assign accept_s = in_ready & in_valid;
    assign start_s  = (state_r == ST_IDLE) & start;
    // The final sample's square is being folded into sse on this edge.
    assign final_s  = out_valid & last2_r;

    // Datapath arithmetic; >>> floors, so negative products truncate toward -inf.
    always_comb begin
        prod_s     = $signed(sext(b1_r)) * $signed(sext(x0_r));
        p_s        = sat_w(prod_s >>> FRAC);
        sum_s      = $signed(sext(b0_r)) + $signed(sext(p1_r));
        yhat_s     = sat_w(sum_s);
        diff_s     = $signed(sext(y1_r)) - $signed(sext(yhat_s));
        resid_s    = sat_w(diff_s);
        sq_prod_s  = $signed(sext(resid)) * $signed(sext(resid));
        sq_s       = sat_w(sq_prod_s >>> FRAC);
        sse_sum_s  = $signed(sext(sse)) + $signed(sext(sq_s));
        sse_next_s = sat_w(sse_sum_s);
    end

    // Run control FSM with registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            b0_r     <= {W{1'b0}};
            b1_r     <= {W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        b0_r     <= b0;
                        b1_r     <= b1;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        state_r  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept_s && in_last) begin
                        in_ready <= 1'b0;
                        state_r  <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (final_s) begin
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    // Sample pipeline: capture, product, prediction/residual, SSE accumulate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0_r      <= {W{1'b0}};
            y0_r      <= {W{1'b0}};
            v0_r      <= 1'b0;
            last0_r   <= 1'b0;
            p1_r      <= {W{1'b0}};
            y1_r      <= {W{1'b0}};
            v1_r      <= 1'b0;
            last1_r   <= 1'b0;
            last2_r   <= 1'b0;
            out_valid <= 1'b0;
            yhat      <= {W{1'b0}};
            resid     <= {W{1'b0}};
            sse       <= {W{1'b0}};
            count     <= {CNTW{1'b0}};
        end else if (start_s) begin
            v0_r      <= 1'b0;
            last0_r   <= 1'b0;
            v1_r      <= 1'b0;
            last1_r   <= 1'b0;
            last2_r   <= 1'b0;
            out_valid <= 1'b0;
            yhat      <= {W{1'b0}};
            resid     <= {W{1'b0}};
            sse       <= {W{1'b0}};
            count     <= {CNTW{1'b0}};
        end else begin
            v0_r    <= accept_s;
            last0_r <= accept_s & in_last;
            if (accept_s) begin
                x0_r <= x;
                y0_r <= y;
            end
            v1_r    <= v0_r;
            last1_r <= v0_r & last0_r;
            if (v0_r) begin
                p1_r <= p_s;
                y1_r <= y0_r;
            end
            out_valid <= v1_r;
            last2_r   <= v1_r & last1_r;
            if (v1_r) begin
                yhat  <= yhat_s;
                resid <= resid_s;
                if (count != {CNTW{1'b1}}) begin
                    count <= count + {{(CNTW-1){1'b0}}, 1'b1};
                end
            end
            if (out_valid) begin
                sse <= sse_next_s;
            end
        end
    end

endmodule

// File: tb/tb_regression_predictor.sv
module tb_regression_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [19:0] b0 = 20'h0;
    logic [19:0] b1 = 20'h0;
    logic        in_valid = 1'b0;
    logic [19:0] x = 20'h0;
    logic [19:0] y = 20'h0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [19:0] yhat;
    logic [19:0] resid;
    logic [19:0] sse;
    logic [7:0]  count;
    logic        busy;
    logic        done;

    regression_predictor #(.W(20), .FRAC(10), .CNTW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .b0(b0), .b1(b1),
        .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y), .in_last(in_last),
        .out_valid(out_valid), .yhat(yhat), .resid(resid), .sse(sse),
        .count(count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model (timetable of expected events) ------
    localparam longint MAXV = 524287;
    localparam longint MINV = -524288;
    localparam int MI = 0, MR = 1, MD = 2, MN = 3;

    typedef struct {
        longint due;
        longint yh;
        longint rs;
        bit     last;
    } ev_t;

    ev_t    pend[$];
    ev_t    sqq[$];
    ev_t    m_e;
    int     m_state = MI;
    int     m_cnt = 0;
    longint m_b0 = 0, m_b1 = 0, m_sse = 0, m_yhat = 0, m_resid = 0, m_cyc = 0;
    longint p_t, yh_t, rs_t;
    bit     m_ready = 0, m_busy = 0, m_done = 0, m_ov = 0;

    function automatic longint clamp(input longint v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    function automatic longint sx(input logic [19:0] v);
        return longint'($signed(v));
    endfunction

    function automatic logic [19:0] lo20(input longint v);
        return v[19:0];
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_state = MI; m_ready = 0; m_busy = 0; m_done = 0; m_ov = 0;
            m_sse = 0; m_cnt = 0; m_b0 = 0; m_b1 = 0; m_yhat = 0; m_resid = 0;
            m_cyc = 0; pend.delete(); sqq.delete();
        end else begin
            m_cyc++;
            m_ov = 0;
            m_done = 0;
            // sse absorbs a sample one cycle after its out_valid
            if (sqq.size() > 0 && sqq[0].due == m_cyc) begin
                m_e = sqq.pop_front();
                m_sse = clamp(m_sse + m_e.yh);
                if (m_e.last) m_done = 1;
            end
            // results appear two edges after acceptance
            if (pend.size() > 0 && pend[0].due == m_cyc) begin
                m_e = pend.pop_front();
                m_ov = 1; m_yhat = m_e.yh; m_resid = m_e.rs;
                if (m_cnt < 255) m_cnt++;
                m_e.due = m_cyc + 1;
                m_e.yh  = clamp((m_e.rs * m_e.rs) >>> 10);
                sqq.push_back(m_e);
            end
            case (m_state)
                MI: if (start) begin
                    m_b0 = sx(b0); m_b1 = sx(b1); m_ready = 1; m_busy = 1;
                    m_sse = 0; m_cnt = 0; m_state = MR;
                end
                MR: if (in_valid) begin
                    p_t  = clamp((m_b1 * sx(x)) >>> 10);
                    yh_t = clamp(m_b0 + p_t);
                    rs_t = clamp(sx(y) - yh_t);
                    m_e.due = m_cyc + 2; m_e.yh = yh_t; m_e.rs = rs_t; m_e.last = in_last;
                    pend.push_back(m_e);
                    if (in_last) begin m_ready = 0; m_state = MD; end
                end
                MD: if (m_done) m_state = MN;
                MN: begin m_busy = 0; m_state = MI; end
                default: m_state = MI;
            endcase
        end
    end

    // ---------------- per-cycle compare -------------------------------------
    logic [19:0] got_y[$];
    logic [19:0] got_r[$];

    initial forever begin
        @(negedge clk);
        chk("in_ready", in_ready, m_ready);
        chk("out_valid", out_valid, m_ov);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("sse", sse, lo20(m_sse));
        chk("count", count, m_cnt[7:0]);
        if (m_ov) begin
            chk("yhat", yhat, lo20(m_yhat));
            chk("resid", resid, lo20(m_resid));
        end
        if (out_valid) begin
            got_y.push_back(yhat);
            got_r.push_back(resid);
        end
    end

    // ---------------- stimulus ----------------------------------------------
    logic [19:0] fin_sse;
    logic [7:0]  fin_cnt;

    task automatic do_start(input logic [19:0] c0, input logic [19:0] c1);
        got_y.delete(); got_r.delete();
        b0 = c0; b1 = c1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive(input logic [19:0] xv, input logic [19:0] yv, input logic lv);
        in_valid = 1'b1; x = xv; y = yv; in_last = lv;
        @(negedge clk);
    endtask

    task automatic idle_in();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Returns on the negedge where done is high (state DONE), or after a bound.
    task automatic run_done(input string nm);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_done_seen"}, done, 1'b1);
        fin_sse = sse;
        fin_cnt = count;
    endtask

    task automatic zero_checks(input string nm);
        chk({nm, "_in_ready"}, in_ready, 1'b0);
        chk({nm, "_out_valid"}, out_valid, 1'b0);
        chk({nm, "_yhat"}, yhat, 20'h0);
        chk({nm, "_resid"}, resid, 20'h0);
        chk({nm, "_sse"}, sse, 20'h0);
        chk({nm, "_count"}, count, 8'h0);
        chk({nm, "_busy"}, busy, 1'b0);
        chk({nm, "_done"}, done, 1'b0);
    endtask

    task automatic basic_run(input string nm);
        do_start(20'h00400, 20'h00800);
        drive(20'h00C00, 20'h02000, 1'b1); idle_in();
        run_done(nm);
        chk({nm, "_n"}, got_y.size(), 1);
        chk({nm, "_yhat"}, got_y[0], 20'h01C00);
        chk({nm, "_resid"}, got_r[0], 20'h00400);
        chk({nm, "_sse"}, fin_sse, 20'h00400);
        chk({nm, "_count"}, fin_cnt, 8'd1);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        zero_checks("reset");
        rst = 1'b0;
        @(negedge clk);

        basic_run("basic");

        // two samples back to back
        do_start(20'h00400, 20'h00800);
        drive(20'h00C00, 20'h02000, 1'b0);
        drive(20'h00400, 20'h00800, 1'b1); idle_in();
        run_done("two");
        chk("two_n", got_y.size(), 2);
        chk("two_yhat1", got_y[1], 20'h00C00);
        chk("two_resid1", got_r[1], 20'hFFC00);
        chk("two_sse", fin_sse, 20'h00800);
        chk("two_count", fin_cnt, 8'd2);
        @(negedge clk);

        // saturation
        do_start(20'h00400, 20'h7FFFF);
        drive(20'h7FFFF, 20'h00000, 1'b1); idle_in();
        run_done("sat");
        chk("sat_yhat", got_y[0], 20'h7FFFF);
        chk("sat_resid", got_r[0], 20'h80001);
        chk("sat_sse", fin_sse, 20'h7FFFF);
        @(negedge clk);

        // negative product truncates toward -inf
        do_start(20'h00000, 20'h00200);
        drive(20'hFFFFF, 20'h00000, 1'b1); idle_in();
        run_done("trunc");
        chk("trunc_yhat", got_y[0], 20'hFFFFF);
        chk("trunc_resid", got_r[0], 20'h00001);
        chk("trunc_sse", fin_sse, 20'h00000);
        @(negedge clk);

        // flow control: in_valid in IDLE and DRAIN, start in RUN and DONE
        in_valid = 1'b1; x = 20'h00100; y = 20'h00100; in_last = 1'b1;
        repeat (3) @(negedge clk);
        idle_in();
        chk("flow_idle_busy", busy, 1'b0);
        chk("flow_idle_count", count, 8'd1);
        do_start(20'h00400, 20'h00800);
        start = 1'b1; b0 = 20'h7FFFF; b1 = 20'h00000;
        drive(20'h00C00, 20'h02000, 1'b0);
        start = 1'b0;
        drive(20'h00400, 20'h00800, 1'b1);
        drive(20'h01000, 20'h00000, 1'b0);
        drive(20'h02000, 20'h00000, 1'b1);
        idle_in();
        run_done("flow");
        chk("flow_count", fin_cnt, 8'd2);
        chk("flow_sse", fin_sse, 20'h00800);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("flow_start_in_done", busy, 1'b0);
        @(negedge clk);
        chk("flow_still_idle", busy, 1'b0);

        // reset one cycle after accepting a sample
        do_start(20'h00400, 20'h00800);
        drive(20'h00C00, 20'h02000, 1'b0); idle_in();
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        zero_checks("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_no_out", got_y.size(), 0);
        basic_run("after_rst");

        // coefficients latched at start
        do_start(20'h00400, 20'h00800);
        b0 = 20'h12345; b1 = 20'h54321;
        drive(20'h00200, 20'h00100, 1'b0);
        drive(20'hFFC00, 20'h00000, 1'b1); idle_in();
        run_done("latch");
        chk("latch_yhat0", got_y[0], 20'h00800);
        chk("latch_resid0", got_r[0], 20'hFF900);
        chk("latch_yhat1", got_y[1], 20'hFFC00);
        chk("latch_resid1", got_r[1], 20'h00400);
        chk("latch_sse", fin_sse, 20'h01040);
        @(negedge clk);

        // count saturates at 255
        do_start(20'h00400, 20'h00100);
        for (int i = 0; i < 260; i++) begin
            drive(20'(i * 1237), 20'(i * 4099), (i == 259));
        end
        idle_in();
        run_done("cntsat");
        chk("cntsat_count", fin_cnt, 8'hFF);
        chk("cntsat_n", got_y.size(), 260);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule
